// File: rtl/maze_mem_responder_if.sv
// rtl/maze_mem_responder_if.sv - load stream and solver bus for the maze storage responder
interface maze_mem_responder_if #(
  parameter int maze_width = 6
);
  logic                  load_valid;
  logic                  load_wall;
  logic                  load_ready;
  logic [maze_width-1:0] row;
  logic [maze_width-1:0] col;
  logic                  maze_oe;
  logic                  maze_we;
  logic                  maze_in;

  modport master (
    output load_valid, load_wall, row, col, maze_oe, maze_we,
    input  load_ready, maze_in
  );

  modport slave (
    input  load_valid, load_wall, row, col, maze_oe, maze_we,
    output load_ready, maze_in
  );
endinterface

// File: rtl/maze_mem_responder.sv
// rtl/maze_mem_responder.sv - maze cell store: row-major load, solver read/mark, readback, exit detect
// Optional VISIT_COUNT_EN builds the saturating visit counter; otherwise visit_count is tied to 0.
module maze_mem_responder #(
  parameter int maze_width = 6,
  parameter int MAZE_SIZE  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  maze_mem_responder_if.slave   bus,
  output logic                  maze_ready,
  input  logic                  dump_en,
  input  logic [maze_width-1:0] dump_row,
  input  logic [maze_width-1:0] dump_col,
  output logic [1:0]            dump_cell,
  output logic                  exit_hit,
  output logic                  addr_err,
  output logic                  wall_err,
  output logic [2*maze_width:0] visit_count
);
  localparam int AW    = 2 * maze_width;
  localparam int CELLS = MAZE_SIZE * MAZE_SIZE;
  localparam logic [AW-1:0] LAST_PTR = AW'(CELLS - 1);

  localparam logic [0:0] S_LOAD  = 1'b0;
  localparam logic [0:0] S_SERVE = 1'b1;

  localparam logic [1:0] C_FREE    = 2'b00;
  localparam logic [1:0] C_WALL    = 2'b01;
  localparam logic [1:0] C_VISITED = 2'b10;

  logic [0:0]    state;
  logic [AW-1:0] ptr;
  logic          maze_in_q;
  logic [1:0]    mem [0:2**AW-1];

  logic          serving;
  logic          load_xfer;
  logic          srv_oor;
  logic          dmp_oor;
  logic [AW-1:0] srv_addr;
  logic [AW-1:0] dmp_addr;
  logic [1:0]    srv_cell;
  logic          on_border;
  logic          we_ok;

  assign serving   = (state == S_SERVE);
  assign load_xfer = (state == S_LOAD) && bus.load_valid;

  assign srv_oor  = (int'(bus.row) >= MAZE_SIZE) || (int'(bus.col) >= MAZE_SIZE);
  assign dmp_oor  = (int'(dump_row) >= MAZE_SIZE) || (int'(dump_col) >= MAZE_SIZE);
  assign srv_addr = AW'(int'(bus.row) * MAZE_SIZE + int'(bus.col));
  assign dmp_addr = AW'(int'(dump_row) * MAZE_SIZE + int'(dump_col));
  assign srv_cell = mem[srv_addr];

  assign on_border = (bus.row == '0) || (bus.col == '0) ||
                     (int'(bus.row) == MAZE_SIZE - 1) || (int'(bus.col) == MAZE_SIZE - 1);

  // A mark only reaches the array when serving and in range; walls are rejected below.
  assign we_ok = serving && bus.maze_we && !srv_oor;

  assign bus.load_ready = (state == S_LOAD);
  assign bus.maze_in    = maze_in_q;
  assign maze_ready     = serving;

  // Array is deliberately not reset; a reload overwrites every cell.
  always_ff @(posedge clk) begin
    if (load_xfer) begin
      mem[ptr] <= {1'b0, bus.load_wall};
    end else if (we_ok && (srv_cell == C_FREE)) begin
      mem[srv_addr] <= C_VISITED;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_LOAD;
      ptr       <= '0;
      maze_in_q <= 1'b1;
      dump_cell <= 2'b00;
      exit_hit  <= 1'b0;
      addr_err  <= 1'b0;
      wall_err  <= 1'b0;
    end else begin
      if (load_xfer) begin
        if (ptr == LAST_PTR) begin
          state <= S_SERVE;
          ptr   <= '0;
        end else begin
          ptr <= ptr + 1'b1;
        end
      end

      if (!serving) begin
        maze_in_q <= 1'b1;
      end else if (bus.maze_oe) begin
        maze_in_q <= srv_oor || (srv_cell == C_WALL);
      end

      if (dump_en) begin
        dump_cell <= dmp_oor ? C_WALL : mem[dmp_addr];
      end

      if (serving && (bus.maze_oe || bus.maze_we) && srv_oor) begin
        addr_err <= 1'b1;
      end
      if (we_ok && (srv_cell == C_WALL)) begin
        wall_err <= 1'b1;
      end
      if (we_ok && (srv_cell != C_WALL) && on_border) begin
        exit_hit <= 1'b1;
      end
    end
  end

`ifdef VISIT_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      visit_count <= '0;
    end else if (we_ok && (srv_cell == C_FREE) && (visit_count != '1)) begin
      visit_count <= visit_count + 1'b1;
    end
  end
`else
  assign visit_count = '0;
`endif

endmodule

// File: tb/tb_maze_mem_responder.sv
// tb/tb_maze_mem_responder.sv - directed bench for maze_mem_responder (64- and 40-cell instances)
module tb_maze_mem_responder;
  localparam int W = 6;
`ifdef VISIT_COUNT_EN
  localparam int VC = 1;
`else
  localparam int VC = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         dump_en;
  logic [W-1:0] dump_row, dump_col;

  logic         ready64, ready40;
  logic [1:0]   dcell64, dcell40;
  logic         exit64, exit40, aerr64, aerr40, werr64, werr40;
  logic [2*W:0] vc64, vc40;

  int checks = 0;
  int errors = 0;

  maze_mem_responder_if #(.maze_width(W)) bus64 ();
  maze_mem_responder_if #(.maze_width(W)) bus40 ();

  maze_mem_responder #(.maze_width(W), .MAZE_SIZE(64)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus64), .maze_ready(ready64),
    .dump_en(dump_en), .dump_row(dump_row), .dump_col(dump_col), .dump_cell(dcell64),
    .exit_hit(exit64), .addr_err(aerr64), .wall_err(werr64), .visit_count(vc64)
  );

  maze_mem_responder #(.maze_width(W), .MAZE_SIZE(40)) dut40 (
    .clk(clk), .rst_n(rst_n), .bus(bus40), .maze_ready(ready40),
    .dump_en(dump_en), .dump_row(dump_row), .dump_col(dump_col), .dump_cell(dcell40),
    .exit_hit(exit40), .addr_err(aerr40), .wall_err(werr40), .visit_count(vc40)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Free cells are column 5 of rows 1..last_free; everything else is wall.
  task automatic load64(input int last_free, input int n);
    for (int i = 0; i < n; i++) begin
      bus64.load_valid = 1'b1;
      bus64.load_wall  = !((i % 64 == 5) && (i / 64 >= 1) && (i / 64 <= last_free));
      tick();
      if (n == 4096 && i == 4094) chk("ready_before_last", 32'(ready64), 32'd0);
      if (n == 4096 && i == 4095) begin
        chk("ready_after_last", 32'(ready64), 32'd1);
        chk("load_ready_after_last", 32'(bus64.load_ready), 32'd0);
      end
    end
    bus64.load_valid = 1'b0;
  endtask

  task automatic load40();
    for (int i = 0; i < 1600; i++) begin
      bus40.load_valid = 1'b1;
      bus40.load_wall  = 1'b0;
      tick();
    end
    bus40.load_valid = 1'b0;
  endtask

  task automatic cyc64(input logic oe, input logic we, input int r, input int c);
    bus64.maze_oe = oe;
    bus64.maze_we = we;
    bus64.row     = W'(r);
    bus64.col     = W'(c);
    tick();
    bus64.maze_oe = 1'b0;
    bus64.maze_we = 1'b0;
  endtask

  task automatic cyc40(input logic oe, input logic we, input int r, input int c);
    bus40.maze_oe = oe;
    bus40.maze_we = we;
    bus40.row     = W'(r);
    bus40.col     = W'(c);
    tick();
    bus40.maze_oe = 1'b0;
    bus40.maze_we = 1'b0;
  endtask

  task automatic dump(input int r, input int c);
    dump_en  = 1'b1;
    dump_row = W'(r);
    dump_col = W'(c);
    tick();
    dump_en  = 1'b0;
  endtask

  task automatic chk_reset64(input string tag);
    chk({tag, "_load_ready"}, 32'(bus64.load_ready), 32'd1);
    chk({tag, "_maze_ready"}, 32'(ready64), 32'd0);
    chk({tag, "_maze_in"}, 32'(bus64.maze_in), 32'd1);
    chk({tag, "_dump_cell"}, 32'(dcell64), 32'd0);
    chk({tag, "_flags"}, {29'd0, exit64, aerr64, werr64}, 32'd0);
    chk({tag, "_visit"}, 32'(vc64), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    dump_en = 1'b0; dump_row = '0; dump_col = '0;
    bus64.load_valid = 1'b0; bus64.load_wall = 1'b0; bus64.row = '0; bus64.col = '0;
    bus64.maze_oe = 1'b0; bus64.maze_we = 1'b0;
    bus40.load_valid = 1'b0; bus40.load_wall = 1'b0; bus40.row = '0; bus40.col = '0;
    bus40.maze_oe = 1'b0; bus40.maze_we = 1'b0;
    tick();
    tick();
    chk_reset64("rst");
    rst_n = 1'b1;

    // Solver activity during load must be ignored.
    cyc64(1'b1, 1'b1, 0, 0);
    chk("load_oe_maze_in", 32'(bus64.maze_in), 32'd1);
    chk("load_we_flags", {29'd0, exit64, aerr64, werr64}, 32'd0);

    load64(62, 4096);

    cyc64(1'b1, 1'b0, 3, 6);
    chk("rd_wall_3_6", 32'(bus64.maze_in), 32'd1);
    cyc64(1'b1, 1'b0, 3, 5);
    chk("rd_free_3_5", 32'(bus64.maze_in), 32'd0);
    cyc64(1'b0, 1'b0, 3, 6);
    chk("rd_hold", 32'(bus64.maze_in), 32'd0);

    cyc64(1'b0, 1'b1, 3, 5);
    cyc64(1'b0, 1'b1, 3, 5);
    dump(3, 5);
    chk("dump_3_5_visited", 32'(dcell64), 32'd2);
    chk("visit_after_double_mark", 32'(vc64), 32'(VC));
    chk("no_exit_interior", 32'(exit64), 32'd0);

    cyc64(1'b0, 1'b1, 3, 6);
    chk("wall_err", 32'(werr64), 32'd1);
    dump(3, 6);
    chk("dump_3_6_wall", 32'(dcell64), 32'd1);
    chk("visit_after_wall_we", 32'(vc64), 32'(VC));

    cyc64(1'b1, 1'b1, 10, 5);
    chk("rbw_maze_in", 32'(bus64.maze_in), 32'd0);
    dump(10, 5);
    chk("dump_10_5", 32'(dcell64), 32'd2);
    chk("visit_two", 32'(vc64), 32'(2 * VC));
    cyc64(1'b1, 1'b0, 3, 5);
    chk("rd_visited", 32'(bus64.maze_in), 32'd0);
    chk("addr_err64_clear", 32'(aerr64), 32'd0);

    load40();
    chk("ready40", 32'(ready40), 32'd1);
    cyc40(1'b1, 1'b0, 2, 3);
    chk("rd40_free", 32'(bus40.maze_in), 32'd0);
    chk("addr_err40_clear", 32'(aerr40), 32'd0);
    cyc40(1'b1, 1'b0, 45, 3);
    chk("rd40_oor_row", 32'(bus40.maze_in), 32'd1);
    chk("addr_err40", 32'(aerr40), 32'd1);
    cyc40(1'b1, 1'b0, 2, 3);
    cyc40(1'b1, 1'b0, 3, 40);
    chk("rd40_oor_col", 32'(bus40.maze_in), 32'd1);
    cyc40(1'b0, 1'b1, 45, 3);
    chk("visit40_oor_we", 32'(vc40), 32'd0);
    chk("exit40_oor_we", 32'(exit40), 32'd0);
    dump(45, 3);
    chk("dump40_oor", 32'(dcell40), 32'd1);
    dump(39, 39);
    chk("dump40_39_39", 32'(dcell40), 32'd0);
    cyc40(1'b0, 1'b1, 39, 1);
    chk("exit40_last_row", 32'(exit40), 32'd1);
    chk("visit40_one", 32'(vc40), 32'(VC));

    // Reset mid-serve, partial load, reset mid-load, then full reload.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    load64(63, 100);
    rst_n = 1'b0;
    tick();
    chk_reset64("rst_midload");
    rst_n = 1'b1;
    load64(63, 4096);
    dump(3, 5);
    chk("reload_overwrote_3_5", 32'(dcell64), 32'd0);

    cyc64(1'b0, 1'b1, 62, 5);
    chk("no_exit_62_5", 32'(exit64), 32'd0);
    cyc64(1'b0, 1'b1, 63, 5);
    chk("exit_63_5", 32'(exit64), 32'd1);
    tick();
    tick();
    chk("exit_sticky", 32'(exit64), 32'd1);
    chk("visit_after_reload", 32'(vc64), 32'(2 * VC));
    rst_n = 1'b0;
    tick();
    chk("exit_cleared", 32'(exit64), 32'd0);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
